// File: rtl/quad_count_seq_pkg.sv
// Shared types and helpers for the sequential quadruple counter.
// Imported by the top level and by the testbench.
package quad_count_pkg;

    localparam int MAX_K = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    function automatic logic [63:0] ncr4(input logic [63:0] n);
        if (n < 64'd4) begin
            return 64'd0;
        end
        return (n * (n - 64'd1) * (n - 64'd2) * (n - 64'd3)) / 64'd24;
    endfunction

endpackage

// File: rtl/quad_count_seq_if.sv
// Request/result bundle between a requester and quad_count_seq.
// Carries the start handshake, captured operands and result.
interface quad_count_seq_if #(
    parameter int N     = 100,
    parameter int CNT_W = 22
);

    logic             start;
    logic [N-1:0]     input_array;
    logic [7:0]       k;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;

    modport master (
        output start,
        output input_array,
        output k,
        input  busy,
        input  done,
        input  count
    );

    modport slave (
        input  start,
        input  input_array,
        input  k,
        output busy,
        output done,
        output count
    );

endinterface

// File: rtl/quad_index_walker.sv
// Lexicographic walker over index tuples i<j<m<l in [0, N-1].
// Holds on the final tuple and flags it with last.
module quad_index_walker #(
    parameter int N     = 100,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [IDX_W-1:0] i,
    output logic [IDX_W-1:0] j,
    output logic [IDX_W-1:0] m,
    output logic [IDX_W-1:0] l,
    output logic             last
);

    localparam logic [IDX_W-1:0] N1 = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] N2 = IDX_W'(N - 2);
    localparam logic [IDX_W-1:0] N3 = IDX_W'(N - 3);
    localparam logic [IDX_W-1:0] N4 = IDX_W'(N - 4);

    assign last = (i == N4) && (j == N3) && (m == N2) && (l == N1);

    // m tops out at N-2, so it may still advance while below that
    always_ff @(posedge clk) begin
        if (rst || load) begin
            i <= IDX_W'(0);
            j <= IDX_W'(1);
            m <= IDX_W'(2);
            l <= IDX_W'(3);
        end else if (step) begin
            if (l < N1) begin
                l <= l + IDX_W'(1);
            end else if (m < N2) begin
                m <= m + IDX_W'(1);
                l <= m + IDX_W'(2);
            end else if (j < N3) begin
                j <= j + IDX_W'(1);
                m <= j + IDX_W'(2);
                l <= j + IDX_W'(3);
            end else if (i < N4) begin
                i <= i + IDX_W'(1);
                j <= i + IDX_W'(2);
                m <= i + IDX_W'(3);
                l <= i + IDX_W'(4);
            end
        end
    end

endmodule

// File: rtl/quad_count_seq.sv
// Time-multiplexed counter of 4-bit tuples whose bit-sum equals k.
// One tuple per cycle through a two-stage sum/compare pipeline.
module quad_count_seq
    import quad_count_pkg::*;
#(
    parameter int N     = 100,
    parameter int IDX_W = 8,
    parameter int CNT_W = 22
) (
    input  logic           clk,
    input  logic           rst,
    quad_count_seq_if.slave bus
);

    localparam int PAD_W = 2 ** IDX_W;

    state_t state;
    state_t state_nx;

    logic [N-1:0]     arr_q;
    logic [7:0]       k_q;
    logic [PAD_W-1:0] arr_pad;

    logic             load;
    logic             step;
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic [IDX_W-1:0] m;
    logic [IDX_W-1:0] l;
    logic             last;

    logic [2:0]       s1_sum;
    logic             s1_valid;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] count_q;
    logic             done_q;

    // padding lets IDX_W-wide indices select bits without width games
    assign arr_pad = {{(PAD_W - N){1'b0}}, arr_q};

    quad_index_walker #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_walker (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .i    (i),
        .j    (j),
        .m    (m),
        .l    (l),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = (bus.k > 8'(MAX_K)) ? FIN : RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: state_nx = FIN;
            FIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arr_q    <= '0;
            k_q      <= '0;
            s1_sum   <= '0;
            s1_valid <= 1'b0;
            acc      <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q   <= (state == FIN);
            s1_valid <= (state == RUN);
            s1_sum   <= {2'b00, arr_pad[i]} + {2'b00, arr_pad[j]}
                      + {2'b00, arr_pad[m]} + {2'b00, arr_pad[l]};
            if (s1_valid && ({5'b0, s1_sum} == k_q) && (acc != '1)) begin
                acc <= acc + CNT_W'(1);
            end
            if (state == FIN) begin
                count_q <= acc;
            end
            if (load) begin
                arr_q <= bus.input_array;
                k_q   <= bus.k;
                acc   <= '0;
            end
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_q;
    assign bus.count = count_q;

endmodule

// File: tb/tb_quad_count_seq.sv
// Self-checking bench for quad_count_seq at N=20 (table) and N=6 (corners).
// Expected counts come from combinatorics; latency from ncr4.
module tb_quad_count_seq;
    import quad_count_pkg::*;

    localparam int LIMIT = 6000;

    typedef struct {
        logic [19:0] arr;
        logic [7:0]  k;
        longint      cnt;
    } vec_t;

    typedef struct {
        longint cnt;
        longint lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst6;
    logic rst20;

    int checks   = 0;
    int failures = 0;
    int dones6   = 0;

    vec_t tv[9];
    exp_t sb[$];

    quad_count_seq_if #(.N(6),  .CNT_W(22)) b6 ();
    quad_count_seq_if #(.N(20), .CNT_W(22)) b20 ();

    quad_count_seq #(.N(6), .IDX_W(8), .CNT_W(22)) u6 (
        .clk (clk),
        .rst (rst6),
        .bus (b6)
    );

    quad_count_seq #(.N(20), .IDX_W(8), .CNT_W(22)) u20 (
        .clk (clk),
        .rst (rst20),
        .bus (b20)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (b6.done) dones6 = dones6 + 1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic run20(input logic [19:0] a, input logic [7:0] kk, input longint ec);
        exp_t e;
        longint lat;
        int blow;
        e.cnt = ec;
        e.lat = (kk > 8'd4) ? 64'd2 : longint'(ncr4(64'd20)) + 3;
        sb.push_back(e);
        @(negedge clk);
        b20.input_array = a;
        b20.k = kk;
        b20.start = 1'b1;
        @(negedge clk);
        b20.start = 1'b0;
        b20.input_array = ~a;
        b20.k = kk ^ 8'h05;
        lat = 1;
        blow = 0;
        while (!b20.done && lat < LIMIT) begin
            if (!b20.busy) blow++;
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check("n20_done_seen", longint'(b20.done), 1);
        check("n20_latency", lat, e.lat);
        check("n20_count", longint'(b20.count), e.cnt);
        check("n20_busy_low_in_run", longint'(blow), 0);
        check("n20_busy_at_done", longint'(b20.busy), 0);
    endtask

    task automatic run6(input logic [5:0] a, input logic [7:0] kk,
                        input longint ec, input bit spam);
        exp_t e;
        longint lat;
        int blow;
        int d0;
        e.cnt = ec;
        e.lat = longint'(ncr4(64'd6)) + 3;
        sb.push_back(e);
        d0 = dones6;
        @(negedge clk);
        b6.input_array = a;
        b6.k = kk;
        b6.start = 1'b1;
        @(negedge clk);
        b6.start = 1'b0;
        lat = 1;
        blow = 0;
        while (!b6.done && lat < LIMIT) begin
            if (!b6.busy) blow++;
            if (spam) begin
                b6.start = 1'b1;
                b6.input_array = 6'($urandom);
                b6.k = 8'($urandom_range(0, 4));
            end
            @(negedge clk);
            lat++;
        end
        b6.start = 1'b0;
        e = sb.pop_front();
        check("n6_latency", lat, e.lat);
        check("n6_count", longint'(b6.count), e.cnt);
        check("n6_busy_low_in_run", longint'(blow), 0);
        repeat (30) @(negedge clk);
        check("n6_done_pulses", longint'(dones6 - d0), 1);
        check("n6_count_held", longint'(b6.count), e.cnt);
    endtask

    initial begin
        longint lat;
        int d0;

        tv[0] = '{20'h00000, 8'd0, 4845};
        tv[1] = '{20'h81088, 8'd4, 1};
        tv[2] = '{20'h81088, 8'd3, 64};
        tv[3] = '{20'h0001F, 8'd3, 150};
        tv[4] = '{20'h0001F, 8'd4, 5};
        tv[5] = '{20'hFFFFF, 8'd9, 0};
        tv[6] = '{20'hFFFFF, 8'd0, 0};
        tv[7] = '{20'hFFFFF, 8'd4, 4845};
        tv[8] = '{20'h0A5C3, 8'd2, 1848};

        rst6 = 1'b1;
        rst20 = 1'b1;
        b6.start = 1'b0;
        b6.input_array = '0;
        b6.k = '0;
        b20.start = 1'b0;
        b20.input_array = '0;
        b20.k = '0;
        repeat (3) @(negedge clk);
        b20.start = 1'b1;
        b6.start = 1'b1;
        @(negedge clk);
        check("rst_busy", longint'(b20.busy), 0);
        check("rst_done", longint'(b20.done), 0);
        check("rst_count", longint'(b20.count), 0);
        check("rst_busy6", longint'(b6.busy), 0);
        b20.start = 1'b0;
        b6.start = 1'b0;
        rst6 = 1'b0;
        rst20 = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 9; t++) begin
            run20(tv[t].arr, tv[t].k, tv[t].cnt);
        end

        run6(6'b101101, 8'd2, 6, 1'b1);

        d0 = dones6;
        @(negedge clk);
        b6.input_array = 6'b101101;
        b6.k = 8'd2;
        b6.start = 1'b1;
        @(negedge clk);
        b6.start = 1'b0;
        lat = 1;
        while (lat < 7) begin
            @(negedge clk);
            lat++;
        end
        check("n6_busy_before_rst", longint'(b6.busy), 1);
        rst6 = 1'b1;
        @(negedge clk);
        rst6 = 1'b0;
        check("n6_rst_busy", longint'(b6.busy), 0);
        check("n6_rst_count", longint'(b6.count), 0);
        check("n6_rst_done", longint'(b6.done), 0);
        repeat (30) @(negedge clk);
        check("n6_rst_no_done", longint'(dones6 - d0), 0);

        run6(6'b000111, 8'd1, 3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
